serial_addsub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor with selectable add/sub mode and carry/borrow chain.

---
 rtl/serial_addsub_pkg.sv | 25 ++
 rtl/addsub_digit.sv | 29 ++
 rtl/serial_addsub.sv | 126 ++++++++++++
 tb/tb_serial_addsub.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: state encoding,
// mode constants and the signed-overflow rule.
package serial_addsub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  // Two's-complement overflow from operand signs and result sign.
  function automatic logic calc_ovf(input logic mode, input logic sa,
                                    input logic sb, input logic sr);
    if (mode == MODE_ADD) return (sa == sb) && (sr != sa);
    else                  return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit ripple slice. In add mode the chain is a carry, in subtract
// mode it is a borrow; the sum/difference bit is a^b^chain either way.
module addsub_digit
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             mode,
  input  logic             chain_in,
  output logic [DIGIT-1:0] s,
  output logic             chain_out
);

  // Ripple the chain bit through DIGIT full-adder / full-subtractor cells.
  always_comb begin
    logic c;
    c = chain_in;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      if (mode == MODE_ADD) c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      else                  c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
    end
    chain_out = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH/DIGIT cycles per operation through a
// single ripple slice, with valid/ready handshakes on input and output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and payload is only meaningful while
// valid is high. Here in_ready is high only in IDLE and out_valid only in DONE,
// so at most one operation is in flight.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             chain;
  logic             mode_q;
  logic             sa;
  logic             sb;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig_s;
  logic             dig_chain;
  logic [WIDTH-1:0] res_next;
  logic             last;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a         (op_a[DIGIT-1:0]),
    .b         (op_b[DIGIT-1:0]),
    .mode      (mode_q),
    .chain_in  (chain),
    .s         (dig_s),
    .chain_out (dig_chain)
  );

  // New digit enters at the top; after NDIG shifts the result is aligned.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_next = dig_s;
    end else begin : g_shift
      assign res_next = {dig_s, res[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last = (cnt == CW'(NDIG - 1));

  // Control FSM plus operand/result shift registers and status capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      chain  <= 1'b0;
      mode_q <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a   <= a;
            op_b   <= b;
            mode_q <= mode;
            chain  <= cin;
            sa     <= a[WIDTH-1];
            sb     <= b[WIDTH-1];
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          res   <= res_next;
          chain <= dig_chain;
          cnt   <= cnt + CW'(1);
          if (last) begin
            // The slice's top bit on the final digit is the result sign.
            cout_q <= dig_chain;
            ovf_q  <= calc_ovf(mode_q, sa, sb, dig_s[DIGIT-1]);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = res;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (DIGIT 4, 1, 16; WIDTH 16) share
// clock and reset. Expected {cout, ovf, result} words go into exp_q when an
// operation is issued and are popped when the unit presents its output.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic        in_valid_v  [NI];
  logic        in_ready_v  [NI];
  logic [15:0] a_v         [NI];
  logic [15:0] b_v         [NI];
  logic        mode_v      [NI];
  logic        cin_v       [NI];
  logic        out_valid_v [NI];
  logic        out_ready_v [NI];
  logic [15:0] result_v    [NI];
  logic        cout_v      [NI];
  logic        ovf_v       [NI];
  logic [1:0]  state_v     [NI];

  logic [17:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    serial_addsub #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .mode      (mode_v[g]),
      .cin       (cin_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .result    (result_v[g]),
      .cout      (cout_v[g]),
      .ovf       (ovf_v[g]),
      .dbg_state (state_v[g])
    );
  end

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int ndig(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
  endfunction

  // Behavioural reference: 17-bit arithmetic, bit 16 is carry or borrow.
  function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                        input logic m, input logic c);
    logic [16:0] full;
    logic        ov;
    if (m == MODE_ADD) full = {1'b0, aa} + {1'b0, bb} + 17'(c);
    else               full = {1'b0, aa} - {1'b0, bb} - 17'(c);
    if (m == MODE_ADD) ov = (aa[15] == bb[15]) && (full[15] != aa[15]);
    else               ov = (aa[15] != bb[15]) && (full[15] != aa[15]);
    return {full[16], ov, full[15:0]};
  endfunction

  // Driver: called at a negedge; waits for in_ready, presents one op for one
  // accept edge, optionally pushes the expected word, returns at the negedge
  // right after the accept edge.
  task automatic send(input int k, input logic [15:0] aa, input logic [15:0] bb,
                      input logic m, input logic c, input bit push,
                      input logic [17:0] exp_word);
    int n;
    n = 0;
    while (in_ready_v[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL send_ready inst=%0d in_ready=%b expected 1", k, in_ready_v[k]);
    end
    a_v[k]        = aa;
    b_v[k]        = bb;
    mode_v[k]     = m;
    cin_v[k]      = c;
    in_valid_v[k] = 1'b1;
    if (push) exp_q.push_back(exp_word);
    @(posedge clk);
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    a_v[k]        = $urandom_range(0, 16'hFFFF);
    b_v[k]        = $urandom_range(0, 16'hFFFF);
  endtask

  // Monitor/scoreboard: waits for out_valid, checks latency, holds off for
  // ready_delay cycles, compares against the queue head, then completes.
  task automatic collect(input int k, input int ready_delay, input bit chk_lat);
    int n;
    logic [17:0] e;
    n = 0;
    while (out_valid_v[k] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (chk_lat) begin
      checks++;
      if (n != ndig(k)) begin
        failures++;
        $display("FAIL latency inst=%0d got %0d cycles expected %0d", k, n, ndig(k));
      end
    end
    repeat (ready_delay) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty inst=%0d got empty queue expected an entry", k);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    if (out_valid_v[k] !== 1'b1) begin
      failures++;
      $display("FAIL out_valid inst=%0d got %b expected 1", k, out_valid_v[k]);
    end
    checks++;
    if (result_v[k] !== e[15:0]) begin
      failures++;
      $display("FAIL result inst=%0d got %h expected %h", k, result_v[k], e[15:0]);
    end
    checks++;
    if (cout_v[k] !== e[17]) begin
      failures++;
      $display("FAIL cout inst=%0d got %b expected %b", k, cout_v[k], e[17]);
    end
    checks++;
    if (ovf_v[k] !== e[16]) begin
      failures++;
      $display("FAIL ovf inst=%0d got %b expected %b", k, ovf_v[k], e[16]);
    end
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    checks++;
    if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
      failures++;
      $display("FAIL release inst=%0d got out_valid=%b in_ready=%b expected 0/1",
               k, out_valid_v[k], in_ready_v[k]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (result_v[k] !== 16'h0 || cout_v[k] !== 1'b0 || ovf_v[k] !== 1'b0 ||
          out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1 || state_v[k] !== S_IDLE) begin
        failures++;
        $display("FAIL %s inst=%0d got res=%h cout=%b ovf=%b ov=%b ir=%b st=%0d expected 0000/0/0/0/1/0",
                 tag, k, result_v[k], cout_v[k], ovf_v[k], out_valid_v[k], in_ready_v[k], state_v[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_released");
  endtask

  // Directed corner vectors with hand-derived expectations, on every instance.
  task automatic test_directed();
    logic [15:0] ta [6] = '{16'h1234, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    logic [15:0] tb [6] = '{16'h0FCD, 16'h0007, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
    logic        tm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] te [6] = '{{2'b00, 16'h2201}, {2'b10, 16'hFFFE}, {2'b01, 16'h7FFF},
                            {2'b01, 16'h8000}, {2'b10, 16'h0000}, {2'b10, 16'hFFFF}};
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 6; i++) begin
        send(k, ta[i], tb[i], tm[i], tc[i], 1'b1, te[i]);
        collect(k, 0, 1'b1);
      end
    end
  endtask

  // Result held while out_ready is low; new requests ignored in DONE.
  task automatic test_hold();
    int n;
    send(0, 16'h1234, 16'h0FCD, MODE_ADD, 1'b0, 1'b1, {2'b00, 16'h2201});
    n = 0;
    while (out_valid_v[0] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid_v[0] = 1'b1;
      a_v[0] = 16'hAAAA;
      b_v[0] = 16'h5555;
      mode_v[0] = MODE_SUB;
      @(negedge clk);
      checks++;
      if (result_v[0] !== 16'h2201 || cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0 ||
          out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || state_v[0] !== S_DONE) begin
        failures++;
        $display("FAIL hold cycle=%0d got res=%h cout=%b ovf=%b ov=%b ir=%b expected 2201/0/0/1/0",
                 i, result_v[0], cout_v[0], ovf_v[0], out_valid_v[0], in_ready_v[0]);
      end
    end
    in_valid_v[0] = 1'b0;
    void'(exp_q.pop_front());
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    checks++;
    if (state_v[0] !== S_IDLE || in_ready_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got st=%0d ir=%b expected 0/1", state_v[0], in_ready_v[0]);
    end
    send(0, 16'h0005, 16'h0007, MODE_SUB, 1'b0, 1'b1, {2'b10, 16'hFFFE});
    collect(0, 0, 1'b1);
  endtask

  // Reset two cycles into RUN aborts the op cleanly.
  task automatic test_reset_mid();
    send(0, 16'h1234, 16'h0FCD, MODE_ADD, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_mid_1");
    @(negedge clk);
    check_idle_zero("reset_mid_2");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
        failures++;
        $display("FAIL abort cycle=%0d got out_valid=%b in_ready=%b expected 0/1",
                 i, out_valid_v[0], in_ready_v[0]);
      end
    end
    send(0, 16'h8000, 16'h0001, MODE_SUB, 1'b0, 1'b1, {2'b01, 16'h7FFF});
    collect(0, 0, 1'b1);
  endtask

  // Random operands (biased toward extremes) against the behavioural model.
  task automatic test_random();
    logic [15:0] ra, rb;
    logic        rm, rc;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 25; i++) begin
        case ($urandom_range(0, 3))
          0:       ra = 16'hFFFF;
          1:       ra = 16'h8000;
          default: ra = 16'($urandom_range(0, 16'hFFFF));
        endcase
        case ($urandom_range(0, 3))
          0:       rb = 16'h7FFF;
          1:       rb = 16'h0000;
          default: rb = 16'($urandom_range(0, 16'hFFFF));
        endcase
        rm = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        send(k, ra, rb, rm, rc, 1'b1, model(ra, rb, rm, rc));
        collect(k, $urandom_range(0, 3), 1'b1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b0;
      a_v[k]         = '0;
      b_v[k]         = '0;
      mode_v[k]      = 1'b0;
      cin_v[k]       = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
